baud_autodetect_ctrl: RTL and testbench

BAUD_AUTODETECT_CTRL -- requirements
Module: baud_autodetect_ctrl

---
 rtl/baud_autodetect_ctrl.sv | 140 ++++++++++++++
 tb/tb_baud_autodetect_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_autodetect_ctrl.sv
// Baud-rate auto-detect: times a 0x55 calibration character and derives the 16x divisor.
// Optional BAUD_MANUAL_WR_EN adds dvsr_wr/dvsr_din for direct divisor loads while idle.
module baud_autodetect_ctrl #(
    parameter int DEFAULT_DVSR = 326,
    parameter int MIN_DVSR     = 27,
    parameter int CNT_W        = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        start_detect,
`ifdef BAUD_MANUAL_WR_EN
    input  logic        dvsr_wr,
    input  logic [11:0] dvsr_din,
`endif
    output logic [11:0] baud_dvsr,
    output logic        dvsr_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        MEASURE   = 2'd2,
        CALC      = 2'd3
    } state_t;

    // Sum width is kept at least 13 bits so the 4095 bound is representable.
    localparam int SW = (CNT_W + 1 > 13) ? CNT_W + 1 : 13;

    state_t           state;
    state_t           state_nxt;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             fall;
    logic [CNT_W-1:0] count;
    logic [1:0]       edge_cnt;
    logic             cnt_full;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    res_full;
    logic             in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall     = rx_prev & ~rx_sync;
    assign cnt_full = (count == {CNT_W{1'b1}});
    assign sum      = SW'(count) + SW'(64);
    assign res_full = sum >> 7;
    assign in_range = (res_full >= SW'(MIN_DVSR)) && (res_full <= SW'(4095));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start_detect) state_nxt = WAIT_FALL;
            WAIT_FALL: if (fall) state_nxt = MEASURE;
            MEASURE: begin
                if (cnt_full) begin
                    state_nxt = IDLE;
                end else if (fall && edge_cnt == 2'd3) begin
                    state_nxt = CALC;
                end
            end
            CALC:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == WAIT_FALL) || (state == MEASURE);
    end

    // The closing edge still increments count, so count equals exactly 128*divisor clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            edge_cnt   <= 2'd0;
            baud_dvsr  <= 12'(DEFAULT_DVSR);
            dvsr_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            dvsr_valid <= 1'b0;
            err        <= 1'b0;
            unique case (state)
                IDLE: begin
`ifdef BAUD_MANUAL_WR_EN
                    if (dvsr_wr && dvsr_din != 12'd0) begin
                        baud_dvsr <= dvsr_din;
                    end
`endif
                end
                WAIT_FALL: begin
                    if (fall) begin
                        count    <= '0;
                        edge_cnt <= 2'd0;
                    end
                end
                MEASURE: begin
                    if (cnt_full) begin
                        err <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (fall) begin
                            edge_cnt <= edge_cnt + 2'd1;
                        end
                    end
                end
                CALC: begin
                    if (in_range) begin
                        baud_dvsr  <= res_full[11:0];
                        dvsr_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_baud_autodetect_ctrl.sv
// Directed bench for baud_autodetect_ctrl; a second short-counter instance covers the timeout path.
module tb_baud_autodetect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        start_detect;
    logic [11:0] baud_dvsr;
    logic        dvsr_valid;
    logic        busy;
    logic        err;

    logic        rx2;
    logic        start2;
    logic [11:0] baud_dvsr2;
    logic        dvsr_valid2;
    logic        busy2;
    logic        err2;

`ifdef BAUD_MANUAL_WR_EN
    logic        dvsr_wr;
    logic [11:0] dvsr_din;
    logic        dvsr_wr2;
    logic [11:0] dvsr_din2;
`endif

    int n_vec;
    int n_err;
    int valid_cnt;
    int err_cnt;
    int both_cnt;
    int err2_cnt;

    baud_autodetect_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .start_detect (start_detect),
`ifdef BAUD_MANUAL_WR_EN
        .dvsr_wr      (dvsr_wr),
        .dvsr_din     (dvsr_din),
`endif
        .baud_dvsr    (baud_dvsr),
        .dvsr_valid   (dvsr_valid),
        .busy         (busy),
        .err          (err)
    );

    baud_autodetect_ctrl #(.CNT_W(10)) dut_short (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx2),
        .start_detect (start2),
`ifdef BAUD_MANUAL_WR_EN
        .dvsr_wr      (dvsr_wr2),
        .dvsr_din     (dvsr_din2),
`endif
        .baud_dvsr    (baud_dvsr2),
        .dvsr_valid   (dvsr_valid2),
        .busy         (busy2),
        .err          (err2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (dvsr_valid) valid_cnt <= valid_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (dvsr_valid && err) both_cnt <= both_cnt + 1;
        if (err2) err2_cnt <= err2_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_detect = 1'b1;
        @(negedge clk);
        start_detect = 1'b0;
    endtask

    // 0x55, 8N1, LSB first; stop bit shortened since the measurement closes on bit 7.
    task automatic send_55(input int bit_clks);
        logic [9:0] frame;
        frame = 10'b1_0101_0101_0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rx = frame[i];
            repeat (bit_clks - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
        wait_cycles(16);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        valid_cnt = 0; err_cnt = 0; both_cnt = 0; err2_cnt = 0;
        rx = 1'b1; start_detect = 1'b0;
        rx2 = 1'b1; start2 = 1'b0;
`ifdef BAUD_MANUAL_WR_EN
        dvsr_wr = 1'b0; dvsr_din = 12'd0;
        dvsr_wr2 = 1'b0; dvsr_din2 = 12'd0;
`endif
        rst_n = 1'b0;
        wait_cycles(4);
        check("reset_dvsr", int'(baud_dvsr), 326);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(dvsr_valid), 0);
        check("reset_err", int'(err), 0);
        rst_n = 1'b1;
        wait_cycles(4);

        // rx activity without start_detect must be ignored
        for (int i = 0; i < 6; i++) begin
            rx = ~rx;
            wait_cycles(50);
        end
        rx = 1'b1;
        wait_cycles(10);
        check("idle_busy", int'(busy), 0);
        check("idle_dvsr", int'(baud_dvsr), 326);

        // 115200 baud -> 27
        pulse_start();
        wait_cycles(1);
        check("armed_busy", int'(busy), 1);
        send_55(434);
        check("b115200_dvsr", int'(baud_dvsr), 27);
        check("b115200_valid", valid_cnt, 1);
        check("b115200_err", err_cnt, 0);
        check("b115200_busy", int'(busy), 0);

        // 9600 baud -> 326
        pulse_start();
        send_55(5208);
        check("b9600_dvsr", int'(baud_dvsr), 326);
        check("b9600_valid", valid_cnt, 2);

        // 64 clk/bit -> 4, below minimum
        pulse_start();
        send_55(64);
        check("fast_dvsr", int'(baud_dvsr), 326);
        check("fast_err", err_cnt, 1);
        check("fast_valid", valid_cnt, 2);
        check("fast_busy", int'(busy), 0);

        // timeout on the 10-bit counter instance: expires 1024 cycles after the edge
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_cycles(4);
        rx2 = 1'b0;
        wait_cycles(900);
        check("tmo_busy_before", int'(busy2), 1);
        check("tmo_err_before", err2_cnt, 0);
        wait_cycles(200);
        check("tmo_busy_after", int'(busy2), 0);
        check("tmo_err", err2_cnt, 1);
        check("tmo_dvsr", int'(baud_dvsr2), 326);
        rx2 = 1'b1;
        wait_cycles(10);

        // reset after the 2nd falling edge of a measurement
        pulse_start();
        send_55(434);
        check("pre_rst_dvsr", int'(baud_dvsr), 27);
        pulse_start();
        @(negedge clk);
        rx = 1'b0;
        wait_cycles(434);
        rx = 1'b1;
        wait_cycles(434);
        rx = 1'b0;
        wait_cycles(100);
        rst_n = 1'b0;
        wait_cycles(2);
        check("midrst_dvsr", int'(baud_dvsr), 326);
        check("midrst_busy", int'(busy), 0);
        rx = 1'b1;
        rst_n = 1'b1;
        wait_cycles(2000);
        check("midrst_valid", valid_cnt, 3);
        check("midrst_err", err_cnt, 1);
        check("midrst_busy_after", int'(busy), 0);

`ifdef BAUD_MANUAL_WR_EN
        @(negedge clk);
        dvsr_wr = 1'b1; dvsr_din = 12'd162;
        @(negedge clk);
        dvsr_wr = 1'b0;
        wait_cycles(1);
        check("wr_dvsr", int'(baud_dvsr), 162);
        check("wr_no_valid", valid_cnt, 3);
        @(negedge clk);
        dvsr_wr = 1'b1; dvsr_din = 12'd0;
        @(negedge clk);
        dvsr_wr = 1'b0;
        wait_cycles(1);
        check("wr_zero", int'(baud_dvsr), 162);
        pulse_start();
        @(negedge clk);
        dvsr_wr = 1'b1; dvsr_din = 12'd100;
        @(negedge clk);
        dvsr_wr = 1'b0;
        wait_cycles(1);
        check("wr_busy", int'(baud_dvsr), 162);
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
`endif

        check("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
